// File: rtl/rv32_reg_file_if.sv
// rv32_reg_file_if: bundles the register-file access signals between the
// decode/writeback logic (master) and the register file (slave).
//   ip_wr_data  [31:0] write data for register ip_rd_addr
//   ip_rd_addr  [4:0]  destination register index
//   ip_rs1_addr [4:0]  source register 1 index
//   ip_rs2_addr [4:0]  source register 2 index
//   ip_wr_en           write enable, takes effect on the next rising edge
//   op_rs1      [31:0] contents of register ip_rs1_addr
//   op_rs2      [31:0] contents of register ip_rs2_addr
interface rv32_reg_file_if;
    logic [31:0] ip_wr_data;
    logic [4:0]  ip_rd_addr;
    logic [4:0]  ip_rs1_addr;
    logic [4:0]  ip_rs2_addr;
    logic        ip_wr_en;
    logic [31:0] op_rs1;
    logic [31:0] op_rs2;

    modport master (
        output ip_wr_data,
        output ip_rd_addr,
        output ip_rs1_addr,
        output ip_rs2_addr,
        output ip_wr_en,
        input  op_rs1,
        input  op_rs2
    );

    modport slave (
        input  ip_wr_data,
        input  ip_rd_addr,
        input  ip_rs1_addr,
        input  ip_rs2_addr,
        input  ip_wr_en,
        output op_rs1,
        output op_rs2
    );
endinterface

// File: rtl/rv32_reg_file.sv
// rv32_reg_file: RV32 integer register file, 32 x 32 bits, two combinational
// read ports and one synchronous write port. x0 is hardwired to zero.
//   ip_clk  rising-edge clock for writes
//   ip_rst  asynchronous active-high reset, clears every register
//   rf      register-file access bundle (slave side)
module rv32_reg_file (
    input  logic               ip_clk,
    input  logic               ip_rst,
    rv32_reg_file_if.slave     rf
);

    // x0 has no storage; only x1..x31 are flops.
    logic [31:0] regs_q [1:31];
    logic [31:0] regs_d [1:31];

    always_comb begin
        for (int i = 1; i < 32; i++) begin
            regs_d[i] = regs_q[i];
            if (rf.ip_wr_en && (rf.ip_rd_addr == 5'(i))) begin
                regs_d[i] = rf.ip_wr_data;
            end
        end
    end

    always_ff @(posedge ip_clk or posedge ip_rst) begin
        if (ip_rst) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads come straight from the flops: no write-to-read bypass, so a
    // pending write is only visible after the edge that stores it.
    always_comb begin
        rf.op_rs1 = 32'h0;
        rf.op_rs2 = 32'h0;
        for (int i = 1; i < 32; i++) begin
            if (rf.ip_rs1_addr == 5'(i)) begin
                rf.op_rs1 = regs_q[i];
            end
            if (rf.ip_rs2_addr == 5'(i)) begin
                rf.op_rs2 = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_rv32_reg_file.sv
// tb_rv32_reg_file: directed scoreboard bench for rv32_reg_file. Stimulus
// pushes expected read values into a queue and raises an event; the monitor
// samples the read ports and compares against the head of the queue.
module tb_rv32_reg_file;

    logic ip_clk;
    logic ip_rst;

    rv32_reg_file_if rf_if ();

    rv32_reg_file u_dut (
        .ip_clk (ip_clk),
        .ip_rst (ip_rst),
        .rf     (rf_if)
    );

    typedef struct {
        string       name;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   n_cmp = 0;
    int   n_err = 0;

    initial ip_clk = 1'b0;
    always #5 ip_clk = ~ip_clk;

    // Monitor: samples the read ports 1 time unit after each request.
    initial begin
        forever begin
            exp_t e;
            @(chk_ev);
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL no_expectation: scoreboard empty when outputs presented");
            end else begin
                e = exp_q.pop_front();
                if (rf_if.op_rs1 !== e.rs1 || rf_if.op_rs2 !== e.rs2) begin
                    n_err++;
                    $display("FAIL %s: got rs1=%h rs2=%h, expected rs1=%h rs2=%h",
                             e.name, rf_if.op_rs1, rf_if.op_rs2, e.rs1, e.rs2);
                end
            end
        end
    end

    task automatic expect_rd(input string nm, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = nm;
        e.rs1  = e1;
        e.rs2  = e2;
        exp_q.push_back(e);
        -> chk_ev;
        #2;
    endtask

    task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
        rf_if.ip_rs1_addr = a1;
        rf_if.ip_rs2_addr = a2;
    endtask

    task automatic set_wr(input logic en, input logic [4:0] rd, input logic [31:0] data);
        rf_if.ip_wr_en   = en;
        rf_if.ip_rd_addr = rd;
        rf_if.ip_wr_data = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ip_rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd31);
        #1;
        ip_rst = 1'b1;
        #1;
        expect_rd("reset_rs5_rs31", 32'h0, 32'h0);

        // Deassert mid-cycle, then sweep every address.
        @(negedge ip_clk);
        ip_rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge ip_clk);
            set_rd(5'(i), 5'(31 - i));
            expect_rd($sformatf("post_reset_x%0d", i), 32'h0, 32'h0);
        end

        // x5..x8 = 1..4 on consecutive edges.
        for (int i = 0; i < 4; i++) begin
            @(negedge ip_clk);
            set_wr(1'b1, 5'(5 + i), 32'(i + 1));
        end
        @(negedge ip_clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd5, 5'd6);
        expect_rd("read_x5_x6", 32'd1, 32'd2);
        set_rd(5'd7, 5'd8);
        expect_rd("read_x7_x8", 32'd3, 32'd4);
        set_rd(5'd0, 5'd0);
        expect_rd("read_x0_x0", 32'h0, 32'h0);

        // Write to x0 is discarded.
        @(negedge ip_clk);
        set_wr(1'b1, 5'd0, 32'hDEADBEEF);
        @(negedge ip_clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd0, 5'd5);
        expect_rd("x0_protect", 32'h0, 32'd1);

        // Write enable low: x5 must hold its value.
        @(negedge ip_clk);
        set_wr(1'b0, 5'd5, 32'hFFFFFFFF);
        repeat (3) @(negedge ip_clk);
        set_rd(5'd5, 5'd5);
        expect_rd("wr_en_gating_same_addr", 32'd1, 32'd1);

        // No bypass: pending write not visible before the edge.
        @(negedge ip_clk);
        set_wr(1'b1, 5'd9, 32'h12345678);
        set_rd(5'd9, 5'd5);
        expect_rd("no_bypass_before_edge", 32'h0, 32'd1);
        @(negedge ip_clk);
        set_wr(1'b0, 5'd0, 32'h0);
        expect_rd("write_after_edge", 32'h12345678, 32'd1);

        // Short reset pulse between edges clears contents at once.
        @(negedge ip_clk);
        ip_rst = 1'b1;
        #1;
        expect_rd("async_reset_pulse", 32'h0, 32'h0);
        ip_rst = 1'b0;
        @(negedge ip_clk);
        set_rd(5'd9, 5'd8);
        expect_rd("after_reset_pulse", 32'h0, 32'h0);

        // Write attempted on an edge while reset is held is not stored.
        set_wr(1'b1, 5'd10, 32'hA5A5A5A5);
        ip_rst = 1'b1;
        @(negedge ip_clk);
        ip_rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd10, 5'd9);
        expect_rd("write_blocked_in_reset", 32'h0, 32'h0);

        // First edge after deassertion does write.
        set_wr(1'b1, 5'd31, 32'hCAFEF00D);
        @(negedge ip_clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd31, 5'd10);
        expect_rd("first_write_after_reset", 32'hCAFEF00D, 32'h0);

        #5;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
